if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline. Holds the 8-bit byte-addressed program counter and the instruction memory. Presents {instruction, pc} to the IF/ID pipeline register every cycle. Honours the hazard unit's PC stall and the branch unit's redirect, raises a flush toward IF/ID on a taken branch, and halts fetch cleanly at the end of the program.

---
 rtl/if_stage.sv | 96 +++++++++
 tb/tb_if_stage.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Holds the byte-addressed program counter and the instruction memory. Every cycle it presents
// {instruction_out, pc_out} to the IF/ID register. A taken-branch redirect replaces the current
// word with a NOP and raises IF_Flush. Fetch stops at the first all-zero word, and only a
// redirect or reset restarts it.
//
// Ports:
//   clk             clock, all state updates on posedge
//   reset           synchronous active-high reset
//   PC_Write        hazard-unit enable, 0 holds the PC (stall)
//   PCSrc           taken-branch redirect
//   branch_target   redirect byte address, force-aligned to a word
//   instruction_out fetched word, or NOP while halted or flushing
//   pc_out          address of instruction_out
//   IF_Flush        squash request toward IF/ID (follows PCSrc)
//   halted          fetch stopped at program end
//   fetch_count     instructions accepted into the pipe, saturating
module if_stage #(
    parameter int unsigned                 IMEM_WORDS = 64,
    parameter string                       IMEM_FILE  = "instructions.mem",
    parameter logic [31:0]                 NOP_INSN   = 32'h00000013,
    // Instruction memory image; word w occupies bits [32*w +: 32].
    parameter logic [IMEM_WORDS*32-1:0]    IMEM_INIT  = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PC_Write,
    input  logic        PCSrc,
    input  logic [7:0]  branch_target,
    output logic [31:0] instruction_out,
    output logic [7:0]  pc_out,
    output logic        IF_Flush,
    output logic        halted,
    output logic [15:0] fetch_count
);

    typedef enum logic {StFetch, StHalt} state_e;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] cnt_inc;
    logic [31:0] raw;
    logic [31:0] imem [IMEM_WORDS];

    // Low target bits are dropped by alignment.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    for (genvar w = 0; w < int'(IMEM_WORDS); w++) begin : g_word
        assign imem[w] = IMEM_INIT[32*w +: 32];
    end

    assign raw     = imem[pc_q[7:2]];
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (PCSrc) begin
            // Redirect beats stall and is the only exit from halt.
            pc_d    = {branch_target[7:2], 2'b00};
            state_d = StFetch;
            cnt_d   = cnt_inc;
        end else if (state_q == StHalt) begin
            // hold
        end else if (!PC_Write) begin
            // stall: halt detection waits until the word is actually accepted
        end else if (raw == 32'h0) begin
            state_d = StHalt;
        end else begin
            pc_d  = pc_q + 8'd4;
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StFetch;
            pc_q    <= 8'h00;
            cnt_q   <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halted          = (state_q == StHalt);
    assign instruction_out = (halted || PCSrc) ? NOP_INSN : raw;
    assign pc_out          = pc_q;
    assign IF_Flush        = PCSrc;
    assign fetch_count     = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h00000013;

    // Image: word 4 is the terminating zero, every other word is nonzero.
    function automatic logic [31:0] word(input int i);
        logic [31:0] w;
        if (i == 4) w = 32'h0;
        else        w = 32'hC0DE_0000 | 32'(i);
        return w;
    endfunction

    function automatic logic [64*32-1:0] build_img();
        logic [64*32-1:0] img;
        for (int i = 0; i < 64; i++) img[32*i +: 32] = word(i);
        return img;
    endfunction

    localparam logic [64*32-1:0] IMG = build_img();

    logic        clk = 1'b0;
    logic        reset;
    logic        PC_Write;
    logic        PCSrc;
    logic [7:0]  branch_target;
    logic [31:0] instruction_out;
    logic [7:0]  pc_out;
    logic        IF_Flush;
    logic        halted;
    logic [15:0] fetch_count;

    if_stage #(
        .IMEM_WORDS(64),
        .IMEM_FILE(""),
        .NOP_INSN(NOP),
        .IMEM_INIT(IMG)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PC_Write(PC_Write),
        .PCSrc(PCSrc),
        .branch_target(branch_target),
        .instruction_out(instruction_out),
        .pc_out(pc_out),
        .IF_Flush(IF_Flush),
        .halted(halted),
        .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    // {instruction, pc, flush, halted, count}
    typedef logic [57:0] obs_t;
    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Drive one cycle of inputs and record what the outputs must be during that cycle.
    task automatic step(input logic rst, input logic pcw, input logic src, input logic [7:0] bt,
                        input logic [7:0] e_pc, input logic [31:0] e_insn, input logic e_fl,
                        input logic e_h, input logic [15:0] e_cnt);
        reset         = rst;
        PC_Write      = pcw;
        PCSrc         = src;
        branch_target = bt;
        exp_q.push_back({e_insn, e_pc, e_fl, e_h, e_cnt});
        @(posedge clk);
        #1;
    endtask

    // Monitor: the DUT presents a result every cycle; compare it mid-cycle.
    always @(negedge clk) begin
        obs_t e, a;
        cyc++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            a = {instruction_out, pc_out, IF_Flush, halted, fetch_count};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL cycle%0d: got insn=%h pc=%h flush=%b halt=%b cnt=%0d, want insn=%h pc=%h flush=%b halt=%b cnt=%0d",
                         cyc, a[57:26], a[25:18], a[17], a[16], a[15:0],
                         e[57:26], e[25:18], e[17], e[16], e[15:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; PC_Write = 1'b1; PCSrc = 1'b0; branch_target = 8'h00;
        @(posedge clk);
        #1;
        // Reset held
        step(1, 1, 0, 8'h00, 8'h00, word(0), 0, 0, 16'd0);
        // Sequential fetch with a 3-cycle stall at 0x08
        step(0, 1, 0, 8'h00, 8'h00, word(0), 0, 0, 16'd0);
        step(0, 1, 0, 8'h00, 8'h04, word(1), 0, 0, 16'd1);
        step(0, 0, 0, 8'h00, 8'h08, word(2), 0, 0, 16'd2);
        step(0, 0, 0, 8'h00, 8'h08, word(2), 0, 0, 16'd2);
        step(0, 0, 0, 8'h00, 8'h08, word(2), 0, 0, 16'd2);
        step(0, 1, 0, 8'h00, 8'h08, word(2), 0, 0, 16'd2);
        step(0, 1, 0, 8'h00, 8'h0C, word(3), 0, 0, 16'd3);
        // Zero word presented, halt the cycle after
        step(0, 1, 0, 8'h00, 8'h10, 32'h0,   0, 0, 16'd4);
        step(0, 1, 0, 8'h00, 8'h10, NOP,     0, 1, 16'd4);
        step(0, 1, 0, 8'h00, 8'h10, NOP,     0, 1, 16'd4);
        // Redirect out of halt to 0x04
        step(0, 1, 1, 8'h04, 8'h10, NOP,     1, 1, 16'd4);
        step(0, 1, 0, 8'h00, 8'h04, word(1), 0, 0, 16'd5);
        step(0, 1, 0, 8'h00, 8'h08, word(2), 0, 0, 16'd6);
        // Taken branch at 0x0C to misaligned 0x02
        step(0, 1, 1, 8'h02, 8'h0C, NOP,     1, 0, 16'd7);
        step(0, 1, 0, 8'h00, 8'h00, word(0), 0, 0, 16'd8);
        // Redirect together with stall: redirect wins, 0x17 aligns to 0x14
        step(0, 0, 1, 8'h17, 8'h04, NOP,     1, 0, 16'd9);
        // Free run through words 5..63, wrap 0xFC -> 0x00
        for (int w = 5; w < 64; w++) begin
            step(0, 1, 0, 8'h00, 8'(w * 4), word(w), 0, 0, 16'(10 + w - 5));
        end
        for (int w = 0; w < 4; w++) begin
            step(0, 1, 0, 8'h00, 8'(w * 4), word(w), 0, 0, 16'(69 + w));
        end
        // Stall on the zero word suppresses halt detection
        step(0, 0, 0, 8'h00, 8'h10, 32'h0,   0, 0, 16'd73);
        step(0, 1, 0, 8'h00, 8'h10, 32'h0,   0, 0, 16'd73);
        step(0, 1, 0, 8'h00, 8'h10, NOP,     0, 1, 16'd73);
        // Reset while halted and redirecting: reset wins
        step(1, 0, 1, 8'h20, 8'h10, NOP,     1, 1, 16'd73);
        step(0, 1, 0, 8'h00, 8'h00, word(0), 0, 0, 16'd0);
        step(0, 1, 0, 8'h00, 8'h04, word(1), 0, 0, 16'd1);
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
